kbd_vga_responder: RTL

Memory-mapped bus responder sitting on the far side of the MCU's read/write handshake bus. It answers MCU reads at the keyboard address from a small scan-code FIFO fed by the keyboard decoder. It answers MCU writes at the VGA address by placing characters into the character memory at a hardware cursor. Read and write channels are independent and may be serviced in the same cycle.

---
 rtl/mmio_pkg.sv | 12 +
 rtl/sync_fifo.sv | 40 ++++
 rtl/kbd_vga_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and channel state types for the keyboard/VGA bus responder.
package mmio_pkg;
    localparam int WORD_W = 32;
    localparam logic [31:0] KBD_ADDR = 32'h0000_1000;
    localparam logic [31:0] VGA_ADDR = 32'h0000_2000;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_SP = 8'h20;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with show-ahead head; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    assign empty  = r_count == '0;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign head   = r_mem[r_rp];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/kbd_vga_responder.sv
// kbd_vga_responder: bus responder serving keyboard reads from a scan-code FIFO
// and VGA character writes into character memory at a hardware cursor.
module kbd_vga_responder #(
    parameter int                 WORD_W     = mmio_pkg::WORD_W,
    parameter logic [WORD_W-1:0] KBD_ADDR   = mmio_pkg::KBD_ADDR,
    parameter logic [WORD_W-1:0] VGA_ADDR   = mmio_pkg::VGA_ADDR,
    parameter int                 FIFO_DEPTH = 8,
    parameter int                 COLS       = 70,
    parameter int                 ROWS       = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          r_enable,
    input  logic [WORD_W-1:0]             r_addr,
    input  logic [2:0]                    r_mode,
    output logic [WORD_W-1:0]             r_data,
    output logic                          r_ready,
    input  logic                          w_enable,
    input  logic [WORD_W-1:0]             w_addr,
    input  logic [2:0]                    w_mode,
    input  logic [WORD_W-1:0]             w_data,
    output logic                          w_ready,
    input  logic                          kbd_valid,
    input  logic [7:0]                    kbd_code,
    output logic                          cm_we,
    output logic [$clog2(ROWS*COLS)-1:0]  cm_addr,
    output logic [7:0]                    cm_data,
    output logic                          overflow
);
    import mmio_pkg::*;
    localparam int AW = $clog2(ROWS*COLS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    r_state_t r_rd_state, w_rd_next;
    w_state_t r_wr_state, w_wr_next;
    logic [7:0] w_head, w_ch, w_cm_data_nx;
    logic w_empty, w_full, w_pop, w_rd_kbd, w_rd_go;
    logic w_wr_go, w_vga, w_nl, w_bs, w_cm_we_nx;
    logic [RW-1:0] r_row, w_row_nx, w_row_inc;
    logic [CW-1:0] r_col, w_col_nx, w_col_wr;
    logic [AW-1:0] w_cm_addr_nx;
    logic w_unused;
    assign w_unused = ^{r_mode, w_mode, w_data[WORD_W-1:8]};
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(kbd_valid), .pop(w_pop), .din(kbd_code),
        .head(w_head), .empty(w_empty), .full(w_full)
    );
    // A keyboard read stalls in R_IDLE until a code is available.
    always_comb begin
        w_rd_kbd  = r_addr == KBD_ADDR;
        w_rd_go   = r_rd_state == R_IDLE && r_enable && (!w_rd_kbd || !w_empty);
        w_pop     = w_rd_go && w_rd_kbd;
        w_rd_next = w_rd_go ? R_RESP : R_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= R_IDLE;
            r_data     <= '0;
            overflow   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_rd_go) r_data <= w_rd_kbd ? {{(WORD_W-8){1'b0}}, w_head} : '0;
            if (kbd_valid && w_full && !w_pop) overflow <= 1'b1;
        end
    end
    assign r_ready = r_rd_state == R_RESP;
    always_comb begin
        w_wr_go      = r_wr_state == W_IDLE && w_enable;
        w_wr_next    = w_wr_go ? W_RESP : W_IDLE;
        w_vga        = w_wr_go && w_addr == VGA_ADDR;
        w_ch         = w_data[7:0];
        w_nl         = w_ch == CH_LF || w_ch == CH_CR;
        w_bs         = w_ch == CH_BS;
        w_row_inc    = r_row == RW'(ROWS-1) ? '0 : r_row + 1'b1;
        w_col_wr     = w_bs ? r_col - 1'b1 : r_col;
        w_cm_addr_nx = AW'(int'(r_row) * COLS + int'(w_col_wr));
        w_cm_data_nx = w_bs ? CH_SP : w_ch;
        w_cm_we_nx   = 1'b0;
        w_row_nx     = r_row;
        w_col_nx     = r_col;
        if (w_vga) begin
            if (w_nl) begin
                w_col_nx = '0;
                w_row_nx = w_row_inc;
            end else if (w_bs) begin
                w_cm_we_nx = r_col != '0;
                w_col_nx   = r_col != '0 ? w_col_wr : r_col;
            end else begin
                w_cm_we_nx = 1'b1;
                w_col_nx   = r_col == CW'(COLS-1) ? '0 : r_col + 1'b1;
                w_row_nx   = r_col == CW'(COLS-1) ? w_row_inc : r_row;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_state <= W_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            cm_we      <= 1'b0;
            cm_addr    <= '0;
            cm_data    <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_row      <= w_row_nx;
            r_col      <= w_col_nx;
            cm_we      <= w_cm_we_nx;
            if (w_cm_we_nx) begin
                cm_addr <= w_cm_addr_nx;
                cm_data <= w_cm_data_nx;
            end
        end
    end
    assign w_ready = r_wr_state == W_RESP;
endmodule
